// File: rtl/seq_imul_radix4.sv
// ---------------------------------------------------------------------------
// seq_imul_radix4 -- sequential radix-4 integer multiplier
//
// Computes iA * iB one radix-4 digit of the multiplier per clock. A start
// is taken in IDLE or DONE. The FSM then spends WIDTH/2 cycles in RUN and
// spends one cycle in DONE, where oDone pulses. During that cycle oResult
// holds the new product.
//
// Parameters
//   WIDTH    operand width in bits (even, 4..32), default 16
//
// Ports
//   Clock    rising-edge clock
//   Reset    synchronous, active-high reset
//   iStart   start request; it is ignored while busy
//   iA, iB   operands; they are sampled only on an accepted start
//   oBusy    high while in RUN
//   oDone    one-cycle pulse; oResult is valid and newly loaded
//   oResult  registered 2*WIDTH-bit product; it holds between operations
//
// Build option
//   SEQ_IMUL_SIGNED_EN  when defined, the operands are two's complement.
//                       The datapath multiplies the magnitudes. The
//                       product is negated when the signs differ.
// ---------------------------------------------------------------------------
module seq_imul_radix4 #(
    parameter int WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PW-1:0]     acc_reg, result_reg;

    logic              start_ok;
    logic              last_digit;
    logic [WIDTH-1:0]  a_in, b_in;
    logic [1:0]        digit;
    logic [1:0]        digits [DIGITS];
    logic [WIDTH+1:0]  multiple;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     prod_final;

    assign start_ok   = iStart && (state_reg != RUN);
    assign last_digit = (cnt_reg == LAST_DIGIT);

`ifdef SEQ_IMUL_SIGNED_EN
    logic neg_reg;

    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). That value still fits
    // in WIDTH bits when the bits are read as unsigned.
    assign a_in = iA[WIDTH-1] ? (~iA + WIDTH'(1)) : iA;
    assign b_in = iB[WIDTH-1] ? (~iB + WIDTH'(1)) : iB;
    assign prod_final = neg_reg ? (~acc_sum + PW'(1)) : acc_sum;
`else
    assign a_in       = iA;
    assign b_in       = iB;
    assign prod_final = acc_sum;
`endif

    // Split the latched multiplier into radix-4 digits. The counter picks one digit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digits[gi] = b_reg[2*gi +: 2];
    end
    assign digit = digits[cnt_reg];

    always_comb begin
        multiple = '0;
        unique case (digit)
            2'd0: multiple = '0;
            2'd1: multiple = {2'b00, a_reg};
            2'd2: multiple = {1'b0, a_reg, 1'b0};
            2'd3: multiple = {1'b0, a_reg, 1'b0} + {2'b00, a_reg};
            default: multiple = '0;
        endcase
    end

    // The largest shift is WIDTH-2. A WIDTH+2-bit multiple therefore never
    // spills past the 2*WIDTH accumulator.
    assign pp      = {{(PW-WIDTH-2){1'b0}}, multiple} << {cnt_reg, 1'b0};
    assign acc_sum = acc_reg + pp;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (iStart) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = iStart ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
`ifdef SEQ_IMUL_SIGNED_EN
            neg_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                a_reg   <= a_in;
                b_reg   <= b_in;
                cnt_reg <= '0;
                acc_reg <= '0;
`ifdef SEQ_IMUL_SIGNED_EN
                neg_reg <= iA[WIDTH-1] ^ iB[WIDTH-1];
`endif
            end else if (state_reg == RUN) begin
                acc_reg <= acc_sum;
                cnt_reg <= cnt_reg + 1'b1;
                // Load the product on the final digit. The result is then
                // valid in the DONE cycle.
                if (last_digit) begin
                    result_reg <= prod_final;
                end
            end
        end
    end

    assign oBusy   = (state_reg == RUN);
    assign oDone   = (state_reg == DONE);
    assign oResult = result_reg;

endmodule
